serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer. Reuses one single-bit adder slice (two half-adder cells plus carry OR) over WIDTH cycles to add two WIDTH-bit operands.
- Owns operand latching, the bit-index counter, the carry flip-flop, result assembly and the start/busy/done handshake.
- Sits between a requesting datapath and the shared bit slice, trading latency for area.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on the accept edge.
- b  input  WIDTH  operand B; latched on the accept edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered carry-out of the MSB; updated together with sum.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n is sampled only on the rising edge of clk; there is no asynchronous path.
- Reset (rst_n == 0 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Bit index=0, carry FF=0, operand and shift registers cleared.
  - Reset overrides every other event at that edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge is the accept edge E0.
  - At E0: latch a/b into shift registers, carry FF <= 0, index <= 0, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Each cycle, the slice adds a_sh[0] + b_sh[0] + carry.
  - Slice sum bit shifts into the MSB of the partial-result register; a_sh and b_sh shift right by 1; carry FF <= slice carry; index increments.
  - When index == WIDTH-1 at an edge:
    - sum <= completed partial result, including the final bit.
    - cout <= final slice carry.
    - Go to DONE.
- DONE:
  - done=1 for exactly one cycle, then unconditionally back to IDLE.
- Latency:
  - done is high during the cycle following edge E0+WIDTH.
  - sum/cout are valid in that same cycle.
  - Back-to-back issue interval is WIDTH+2 cycles.
- Outputs:
  - sum/cout never show partial values; they change only at the completion edge or on reset.
  - busy is high in RUN and DONE.
- Boundary conditions:
  - start in RUN or DONE is ignored; no queueing.
  - start held high continuously is re-accepted in the first IDLE cycle.
  - Changes on a/b after E0 have no effect on the in-flight result.
  - Overflow wraps modulo 2^WIDTH; the carry out of bit WIDTH-1 appears only on cout.
  - Reset in the middle of RUN aborts the operation: no done pulse, and sum/cout read 0.
- Implementation: index counter width is clog2(WIDTH); no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched at E0.
  - When the latched sub=1:
    - The B shift register loads ~b.
    - The carry FF initialises to 1.
    - The result is a-b mod 2^WIDTH.
    - cout=1 means no borrow (a >= b unsigned).
  - Latched sub=0 behaves identically to the add-only build.
- Not defined: sub port is absent; the carry FF always initialises to 0; add only.

Test Plan:
1. Reset check: rst_n=0 for 2 edges with start=1 and a=8'hFF -> busy=0, done=0, sum=8'h00, cout=0; no accept occurs during reset.
2. Basic add, WIDTH=8: a=8'h35, b=8'h42, start pulsed for 1 cycle -> busy high from the cycle after E0; done pulses once in the cycle after E0+8; sum=8'h77, cout=0; busy low the following cycle.
3. Carry and wrap: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
4. Handshake:
   - Hold start=1 and change a/b to 8'h00 at E0+3 -> first result is still from the latched operands (8'h35+8'h42 -> 8'h77).
   - A second accept occurs in the first IDLE cycle, with a done pulse WIDTH+2 cycles after the first.
   - sum holds 8'h77 until the second completion.
5. Mid-run reset: rst_n=0 at E0+4 during an 8'h35+8'h42 operation -> state IDLE, busy=0 next cycle, no done pulse, sum=8'h00, cout=0.
6. With SERIAL_ADDER_SUB_EN defined, sub=1:
   - a=8'h10, b=8'h20 -> sum=8'hF0, cout=0.
   - a=8'h20, b=8'h10 -> sum=8'h10, cout=1.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - request/result bundle for serial_adder_ctrl
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (output start, a, b, sub, input busy, done, sum, cout);
   modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
   modport master (output start, a, b, input busy, done, sum, cout);
   modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer over one shared full-adder slice
// Define SERIAL_ADDER_SUB_EN to add a latched subtract mode (a - b, cout = no borrow).
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_ctrl_if.slave  bus
);
   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_sh, b_sh, part, sum_r;
   logic             carry, cout_r;
   logic             busy_c, done_c;
   logic             accept, last;
   logic             load_sub;

   // Shared slice: two half-adder cells plus the carry OR.
   logic ha1_s, ha1_c, ha2_c, slice_s, slice_c;
   assign ha1_s   = a_sh[0] ^ b_sh[0];
   assign ha1_c   = a_sh[0] & b_sh[0];
   assign slice_s = ha1_s ^ carry;
   assign ha2_c   = ha1_s & carry;
   assign slice_c = ha1_c | ha2_c;

`ifdef SERIAL_ADDER_SUB_EN
   assign load_sub = bus.sub;
`else
   assign load_sub = 1'b0;
`endif

   assign accept = (state == IDLE) && bus.start;
   assign last   = (state == RUN) && (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (idx == LAST_IDX) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state)
         RUN:     busy_c = 1'b1;
         DONE:    begin busy_c = 1'b1; done_c = 1'b1; end
         default: ;
      endcase
   end

   // Subtraction is a + ~b + 1, so only the B load and the carry seed change.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         part   <= '0;
         carry  <= 1'b0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else if (accept) begin
         idx   <= '0;
         a_sh  <= bus.a;
         b_sh  <= load_sub ? ~bus.b : bus.b;
         part  <= '0;
         carry <= load_sub;
      end else if (state == RUN) begin
         idx   <= idx + 1'b1;
         a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
         part  <= {slice_s, part[WIDTH-1:1]};
         carry <= slice_c;
         if (last) begin
            sum_r  <= {slice_s, part[WIDTH-1:1]};
            cout_r <= slice_c;
         end
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl
// Define SERIAL_ADDER_SUB_EN to also exercise subtract mode.
module tb_serial_adder_ctrl;
   localparam int W = 8;
   localparam longint P = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();
   serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      longint       t;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
      exp_t e;
      int unsigned ai, bi, r;
      ai = av;
      bi = bv;
      if (sv) begin
         r   = (ai + (1 << W) - bi) % (1 << W);
         e.s = W'(r);
         e.c = (ai >= bi);
      end else begin
         r   = ai + bi;
         e.s = W'(r % (1 << W));
         e.c = (r >= (1 << W));
      end
      e.t = 0;
      return e;
   endfunction

   task automatic push(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input longint t);
      exp_t e;
      e   = model(av, bv, sv);
      e.t = t;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 at %0t required no pulse", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sum", 32'(bus.sum), 32'(e.s));
            chk("cout", 32'(bus.cout), 32'(e.c));
            chk("done_time", 32'($time), 32'(e.t));
         end
      end
   end

   task automatic set_sub(input logic sv);
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub = sv;
`else
      if (sv) $display("note: subtract requested in add-only build");
`endif
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) return;
      end
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy=%b required 0 within 64 cycles", bus.busy);
   endtask

   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
      wait_idle();
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      set_sub(sv);
      push(av, bv, sv, $time + P * (W + 1));
      @(negedge clk);
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      set_sub(1'($urandom));
   endtask

   initial begin
      #(P * 20000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint t0;
      logic   rs;
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.a     = 8'hFF;
      bus.b     = 8'hFF;
      set_sub(1'b0);
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_sum", 32'(bus.sum), 32'd0);
      chk("reset_cout", 32'(bus.cout), 32'd0);
      bus.start = 1'b0;
      rst_n     = 1'b1;

      issue(8'h35, 8'h42, 1'b0);
      issue(8'hFF, 8'h01, 1'b0);
      issue(8'h80, 8'h80, 1'b0);

      // Start held high: operand change mid-run, then re-accept on first IDLE cycle.
      wait_idle();
      t0        = $time;
      bus.a     = 8'h35;
      bus.b     = 8'h42;
      bus.start = 1'b1;
      set_sub(1'b0);
      push(8'h35, 8'h42, 1'b0, t0 + P * (W + 1));
      push(8'h00, 8'h00, 1'b0, t0 + P * (W + 1) + P * (W + 2));
      repeat (3) @(negedge clk);
      bus.a = 8'h00;
      bus.b = 8'h00;
      repeat (W) @(negedge clk);
      bus.start = 1'b0;
      chk("sum_hold", 32'(bus.sum), 32'h77);
      chk("busy_second_op", 32'(bus.busy), 32'd1);

      // Mid-run reset after leaving a nonzero result behind.
      issue(8'hFF, 8'hFF, 1'b0);
      wait_idle();
      bus.a     = 8'h35;
      bus.b     = 8'h42;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_sum", 32'(bus.sum), 32'd0);
      chk("abort_cout", 32'(bus.cout), 32'd0);
      rst_n = 1'b1;
      repeat (W + 4) @(negedge clk);
      chk("abort_idle", 32'(bus.busy), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
      issue(8'h10, 8'h20, 1'b1);
      issue(8'h20, 8'h10, 1'b1);
`endif

      for (int i = 0; i < 30; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         issue(W'($urandom), W'($urandom), rs);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
